// File: rtl/ac97_rx_deframer_pkg.sv
// Shared constants, frame layout and types for the AC-link receive deframer.
// Frame bits arrive MSB first, so frame bit k lands at shift register index FRAME_BITS-1-k.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int SLOT_W     = 20;
    localparam int PCM_W      = 16;
    localparam int TAG_W      = 16;
    localparam int CNT_W      = 8;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 16;

    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    function automatic int slot_start(input int n);
        return TAG_W + SLOT_W * (n - 1);
    endfunction

    function automatic int tag_pos(input int tag_bit);
        return FRAME_BITS - TAG_W + tag_bit;
    endfunction

    function automatic int slot_msb(input int n);
        return FRAME_BITS - 1 - slot_start(n);
    endfunction

    localparam int SLOT1_MSB = slot_msb(1);
    localparam int SLOT2_MSB = slot_msb(2);
    localparam int SLOT3_MSB = slot_msb(3);
    localparam int SLOT4_MSB = slot_msb(4);

    typedef enum logic {HUNT, SYNCED} rx_state_e;

    // Only the frame fields the decoder consumes.
    typedef struct packed {
        logic                ready;
        logic                slot1_valid;
        logic                slot2_valid;
        logic                slot3_valid;
        logic                slot4_valid;
        logic                read_flag;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [PCM_W-1:0]    left;
        logic [PCM_W-1:0]    right;
    } rx_fields_t;

endpackage

// File: rtl/ac97_rx_deframer_if.sv
// Consumer-side bundle of the deframer: codec status, register read-back and PCM capture.
interface ac97_rx_deframer_if;
    import ac97_pkg::*;

    logic                codec_ready;
    logic                status_valid;
    logic [ADDR_W-1:0]   status_addr;
    logic [DATA_W-1:0]   status_data;
    logic                status_ack;
    logic                status_ovf;
    logic                pcm_valid;
    logic [PCM_W-1:0]    pcm_left;
    logic [PCM_W-1:0]    pcm_right;
    logic                locked;
    logic [CNT_W-1:0]    sync_err_cnt;

    modport master (
        output codec_ready, status_valid, status_addr, status_data, status_ovf,
        output pcm_valid, pcm_left, pcm_right, locked, sync_err_cnt,
        input  status_ack
    );

    modport slave (
        input  codec_ready, status_valid, status_addr, status_data, status_ovf,
        input  pcm_valid, pcm_left, pcm_right, locked, sync_err_cnt,
        output status_ack
    );

endinterface

// File: rtl/ac97_rx_deframer_shifter.sv
// Bit counter and frame shift register; flags frame completion and SYNC rises
// that land anywhere other than the last bit of a frame.
module ac97_rx_shifter
    import ac97_pkg::*;
(
    input  logic       ac97_bitclk,
    input  logic       ac97_rst,
    input  logic       active,
    input  logic       sync_rise,
    input  logic       sdata,
    output rx_fields_t fields,
    output logic       frame_done,
    output logic       misalign
);

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  last_bit;

    assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign misalign = active & sync_rise & ~last_bit;

    // A rise while hunting or mid-frame restarts the count; the wrap at the last bit is natural.
    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            bit_cnt    <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= active & last_bit;
            if (sync_rise && (!active || !last_bit)) begin
                bit_cnt <= '0;
            end else if (active) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (active) begin
                frame <= {frame[FRAME_BITS-2:0], sdata};
            end
        end
    end

    assign fields.ready       = frame[tag_pos(TAG_READY)];
    assign fields.slot1_valid = frame[tag_pos(TAG_SLOT1)];
    assign fields.slot2_valid = frame[tag_pos(TAG_SLOT2)];
    assign fields.slot3_valid = frame[tag_pos(TAG_SLOT3)];
    assign fields.slot4_valid = frame[tag_pos(TAG_SLOT4)];
    assign fields.read_flag   = frame[SLOT1_MSB];
    assign fields.addr        = frame[SLOT1_MSB-1 -: ADDR_W];
    assign fields.data        = frame[SLOT2_MSB -: DATA_W];
    assign fields.left        = frame[SLOT3_MSB -: PCM_W];
    assign fields.right       = frame[SLOT4_MSB -: PCM_W];

endmodule

// File: rtl/ac97_rx_deframer.sv
// AC-link receive deframer: SYNC alignment FSM, lock tracking and decode of TAG,
// register read-back (slots 1/2) and PCM capture (slots 3/4).
module ac97_rx_deframer
    import ac97_pkg::*;
(
    input  logic                ac97_bitclk,
    input  logic                ac97_rst,
    input  logic                ac97_sync,
    input  logic                ac97_sdata_in,
    ac97_rx_deframer_if.master  rx
);

    rx_state_e          state;
    rx_state_e          next_state;
    logic               sync_q;
    logic               sync_rise;
    logic               active;
    rx_fields_t         fields;
    logic               frame_done;
    logic               misalign;
    logic               decode;
    logic               new_word;

    logic               codec_ready;
    logic               status_valid;
    logic [ADDR_W-1:0]  status_addr;
    logic [DATA_W-1:0]  status_data;
    logic               status_ovf;
    logic               pcm_valid;
    logic [PCM_W-1:0]   pcm_left;
    logic [PCM_W-1:0]   pcm_right;
    logic               locked;
    logic [CNT_W-1:0]   sync_err_cnt;

    assign sync_rise = ac97_sync & ~sync_q;
    assign active    = (state == SYNCED);

    ac97_rx_shifter u_shifter (
        .ac97_bitclk (ac97_bitclk),
        .ac97_rst    (ac97_rst),
        .active      (active),
        .sync_rise   (sync_rise),
        .sdata       (ac97_sdata_in),
        .fields      (fields),
        .frame_done  (frame_done),
        .misalign    (misalign)
    );

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            state  <= HUNT;
            sync_q <= 1'b0;
        end else begin
            state  <= next_state;
            sync_q <= ac97_sync;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HUNT:    if (sync_rise) next_state = SYNCED;
            SYNCED:  next_state = SYNCED;
            default: next_state = HUNT;
        endcase
    end

    // The lock flag seen here is the one earned by earlier frames, so a frame only decodes once trusted.
    assign decode   = frame_done & locked;
    assign new_word = decode & fields.slot1_valid & fields.slot2_valid & ~fields.read_flag;

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            codec_ready  <= 1'b0;
            status_valid <= 1'b0;
            status_addr  <= '0;
            status_data  <= '0;
            status_ovf   <= 1'b0;
            pcm_valid    <= 1'b0;
            pcm_left     <= '0;
            pcm_right    <= '0;
            locked       <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            pcm_valid <= 1'b0;
            if (decode) begin
                codec_ready <= fields.ready;
                pcm_valid   <= fields.slot3_valid | fields.slot4_valid;
                if (fields.slot3_valid) pcm_left  <= fields.left;
                if (fields.slot4_valid) pcm_right <= fields.right;
            end

            // An ack landing with a new word frees the slot for it, so no overflow then.
            if (new_word && status_valid && !rx.status_ack) begin
                status_ovf <= 1'b1;
            end else if (new_word) begin
                status_valid <= 1'b1;
                status_addr  <= fields.addr;
                status_data  <= fields.data;
            end else if (rx.status_ack) begin
                status_valid <= 1'b0;
            end

            if (misalign) begin
                locked <= 1'b0;
                if (sync_err_cnt != {CNT_W{1'b1}}) sync_err_cnt <= sync_err_cnt + CNT_W'(1);
            end else if (frame_done) begin
                locked <= 1'b1;
            end
        end
    end

    assign rx.codec_ready  = codec_ready;
    assign rx.status_valid = status_valid;
    assign rx.status_addr  = status_addr;
    assign rx.status_data  = status_data;
    assign rx.status_ovf   = status_ovf;
    assign rx.pcm_valid    = pcm_valid;
    assign rx.pcm_left     = pcm_left;
    assign rx.pcm_right    = pcm_right;
    assign rx.locked       = locked;
    assign rx.sync_err_cnt = sync_err_cnt;

endmodule

// File: tb/tb_ac97_rx_deframer.sv
// Frame-level bench: builds AC-link frames from TAG/slot fields, predicts outputs per edge
// from the frame rules, and compares every cycle plus a few hand-computed values.
module tb_ac97_rx_deframer;
    import ac97_pkg::*;

    logic ac97_bitclk = 1'b0;
    logic ac97_rst = 1'b1;
    logic ac97_sync = 1'b0;
    logic ac97_sdata_in = 1'b0;

    ac97_rx_deframer_if rx_if ();

    ac97_rx_deframer dut (
        .ac97_bitclk   (ac97_bitclk),
        .ac97_rst      (ac97_rst),
        .ac97_sync     (ac97_sync),
        .ac97_sdata_in (ac97_sdata_in),
        .rx            (rx_if)
    );

    always #5 ac97_bitclk = ~ac97_bitclk;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int pcm_pulses = 0;
    logic check_en = 1'b0;

    // Model state, advanced once per clock edge.
    logic        m_ready, m_sv, m_ovf, m_pv, m_locked;
    logic [6:0]  m_addr;
    logic [15:0] m_data, m_left, m_right;
    int          m_err;

    // Last complete frame awaiting decode, and a pending misaligned-SYNC edge.
    int          dec_edge = -1;
    int          mis_edge = -1;
    logic [15:0] p_tag;
    logic [19:0] p_s1, p_s2, p_s3, p_s4;

    int   ack_mode = 0;
    int   ack_edge = -1;
    logic ack_on_decode = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got %0h want %0h", name, edge_n, act, exp);
        end
    endtask

    function automatic void modelReset();
        m_ready = 0; m_sv = 0; m_ovf = 0; m_pv = 0; m_locked = 0;
        m_addr = 0; m_data = 0; m_left = 0; m_right = 0; m_err = 0;
        dec_edge = -1;
        mis_edge = -1;
    endfunction

    task automatic modelEdge();
        logic dec;
        logic new_word;
        logic ack;
        ack = rx_if.status_ack;
        if (ac97_rst) begin
            modelReset();
        end else begin
            m_pv = 0;
            dec = (edge_n == dec_edge);
            new_word = 0;
            if (dec && m_locked) begin
                m_ready = p_tag[15];
                m_pv = p_tag[12] | p_tag[11];
                if (p_tag[12]) m_left = p_s3[19:4];
                if (p_tag[11]) m_right = p_s4[19:4];
                new_word = p_tag[14] & p_tag[13] & ~p_s1[19];
            end
            if (new_word) begin
                if (m_sv && !ack) m_ovf = 1;
                else begin
                    m_addr = p_s1[18:12];
                    m_data = p_s2[19:4];
                    m_sv = 1;
                end
            end else if (ack) begin
                m_sv = 0;
            end
            if (edge_n == mis_edge) begin
                m_locked = 0;
                if (m_err < 255) m_err++;
            end else if (dec) begin
                m_locked = 1;
            end
        end
    endtask

    task automatic tick();
        logic a;
        a = 1'b0;
        if (ack_mode == 1) a = ($urandom_range(0, 23) == 0);
        if (edge_n + 1 == ack_edge) a = 1'b1;
        if (ack_on_decode && (edge_n + 1 == dec_edge)) a = 1'b1;
        rx_if.status_ack = a;
        @(posedge ac97_bitclk);
        edge_n++;
        modelEdge();
        #1;
    endtask

    function automatic logic [255:0] buildFrame(input logic [15:0] tag, input logic [19:0] s1,
                                                input logic [19:0] s2, input logic [19:0] s3,
                                                input logic [19:0] s4);
        logic [255:0] fb;
        for (int k = 0; k < 8; k++) fb[32*k +: 32] = $urandom;
        for (int i = 0; i < 16; i++) fb[i] = tag[15-i];
        for (int j = 0; j < 20; j++) begin
            fb[16+j] = s1[19-j];
            fb[36+j] = s2[19-j];
            fb[56+j] = s3[19-j];
            fb[76+j] = s4[19-j];
        end
        return fb;
    endfunction

    // Sends bit 0..len-1 of a frame (index = transmission order); SYNC is high for the
    // first 15 bits and, when rise_end is set, rises again on the last bit sent.
    task automatic applyStimulus(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                                 input logic [19:0] s3, input logic [19:0] s4, input int len,
                                 input logic rise_end);
        logic [255:0] fb;
        fb = buildFrame(tag, s1, s2, s3, s4);
        for (int i = 0; i < len; i++) begin
            ac97_sdata_in = fb[i];
            ac97_sync = (i < 15) || (i == len - 1 && rise_end);
            if (i == len - 1 && rise_end && len < 256) mis_edge = edge_n + 1;
            tick();
        end
        if (len == 256) begin
            dec_edge = edge_n + 1;
            p_tag = tag; p_s1 = s1; p_s2 = s2; p_s3 = s3; p_s4 = s4;
        end
    endtask

    task automatic plainFrame();
        applyStimulus(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256, 1'b1);
    endtask

    task automatic doReset();
        ac97_rst = 1'b1;
        ac97_sync = 1'b0;
        repeat (3) tick();
        ac97_rst = 1'b0;
    endtask

    task automatic startSync();
        ac97_sync = 1'b0;
        repeat (4) tick();
        ac97_sync = 1'b1;
        tick();
    endtask

    // The single per-cycle compare against the model.
    always @(negedge ac97_bitclk) begin
        if (check_en) begin
            checkOutput("codec_ready", 32'(rx_if.codec_ready), 32'(m_ready));
            checkOutput("status_valid", 32'(rx_if.status_valid), 32'(m_sv));
            checkOutput("status_addr", 32'(rx_if.status_addr), 32'(m_addr));
            checkOutput("status_data", 32'(rx_if.status_data), 32'(m_data));
            checkOutput("status_ovf", 32'(rx_if.status_ovf), 32'(m_ovf));
            checkOutput("pcm_valid", 32'(rx_if.pcm_valid), 32'(m_pv));
            checkOutput("pcm_left", 32'(rx_if.pcm_left), 32'(m_left));
            checkOutput("pcm_right", 32'(rx_if.pcm_right), 32'(m_right));
            checkOutput("locked", 32'(rx_if.locked), 32'(m_locked));
            checkOutput("sync_err_cnt", 32'(rx_if.sync_err_cnt), 32'(m_err));
            if (rx_if.pcm_valid === 1'b1) pcm_pulses++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses_before;
        int len;
        rx_if.status_ack = 1'b0;
        doReset();
        check_en = 1'b1;
        checkOutput("rst_locked", 32'(rx_if.locked), 32'h0);
        checkOutput("rst_status_valid", 32'(rx_if.status_valid), 32'h0);
        checkOutput("rst_err_cnt", 32'(rx_if.sync_err_cnt), 32'h0);

        $display("[TB] aligned frames with tag 8000");
        startSync();
        repeat (3) plainFrame();
        checkOutput("lock_after_frames", 32'(rx_if.locked), 32'h1);
        checkOutput("ready_after_frames", 32'(rx_if.codec_ready), 32'h1);
        checkOutput("no_pcm_pulses", 32'(pcm_pulses), 32'h0);

        $display("[TB] status read-back and ack");
        applyStimulus(16'hE000, 20'h26000, 20'h000F0, 20'h0, 20'h0, 256, 1'b1);
        ack_edge = edge_n + 50;
        plainFrame();
        checkOutput("status_addr_lit", 32'(rx_if.status_addr), 32'h26);
        checkOutput("status_data_lit", 32'(rx_if.status_data), 32'h000F);
        checkOutput("status_acked", 32'(rx_if.status_valid), 32'h0);

        $display("[TB] ack coinciding with a new word");
        applyStimulus(16'hE000, 20'h11000, 20'h11110, 20'h0, 20'h0, 256, 1'b1);
        applyStimulus(16'hE000, 20'h22000, 20'h22220, 20'h0, 20'h0, 256, 1'b1);
        ack_on_decode = 1'b1;
        plainFrame();
        ack_on_decode = 1'b0;
        checkOutput("word2_addr", 32'(rx_if.status_addr), 32'h22);
        checkOutput("word2_data", 32'(rx_if.status_data), 32'h2222);
        checkOutput("word2_no_ovf", 32'(rx_if.status_ovf), 32'h0);

        $display("[TB] overflow with no ack");
        ack_edge = edge_n + 10;
        applyStimulus(16'hE000, 20'h33000, 20'h33330, 20'h0, 20'h0, 256, 1'b1);
        applyStimulus(16'hE000, 20'h44000, 20'h44440, 20'h0, 20'h0, 256, 1'b1);
        plainFrame();
        checkOutput("ovf_kept_addr", 32'(rx_if.status_addr), 32'h33);
        checkOutput("ovf_flag", 32'(rx_if.status_ovf), 32'h1);

        $display("[TB] pcm capture");
        ack_edge = edge_n + 5;
        pulses_before = pcm_pulses;
        applyStimulus(16'h9800, 20'h0, 20'h0, 20'h12345, 20'hABCDE, 256, 1'b1);
        plainFrame();
        checkOutput("pcm_one_pulse", 32'(pcm_pulses - pulses_before), 32'h1);
        checkOutput("pcm_left_lit", 32'(rx_if.pcm_left), 32'h1234);
        checkOutput("pcm_right_lit", 32'(rx_if.pcm_right), 32'hABCD);

        $display("[TB] misaligned SYNC at count 100");
        applyStimulus(16'hFFFF, 20'h0, 20'h0, 20'h0, 20'h0, 101, 1'b1);
        checkOutput("err_cnt_one", 32'(rx_if.sync_err_cnt), 32'h1);
        checkOutput("unlocked", 32'(rx_if.locked), 32'h0);
        plainFrame();
        plainFrame();
        checkOutput("relocked", 32'(rx_if.locked), 32'h1);

        $display("[TB] error counter saturation");
        repeat (300) applyStimulus(16'($urandom), 20'h0, 20'h0, 20'h0, 20'h0, 20, 1'b1);
        checkOutput("err_cnt_sat", 32'(rx_if.sync_err_cnt), 32'hFF);
        plainFrame();
        plainFrame();

        $display("[TB] randomized frames");
        ack_mode = 1;
        repeat (40) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 255) : 256;
            applyStimulus(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                          20'($urandom), len, 1'b1);
        end
        ack_mode = 0;

        $display("[TB] reset mid-frame");
        applyStimulus(16'hF800, 20'h55000, 20'h55550, 20'h13579, 20'h2468A, 128, 1'b0);
        doReset();
        checkOutput("rst2_pcm_left", 32'(rx_if.pcm_left), 32'h0);
        checkOutput("rst2_err_cnt", 32'(rx_if.sync_err_cnt), 32'h0);
        checkOutput("rst2_ovf", 32'(rx_if.status_ovf), 32'h0);
        startSync();
        applyStimulus(16'hF800, 20'h66000, 20'h66660, 20'h11111, 20'h22222, 256, 1'b1);
        applyStimulus(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256, 1'b1);
        checkOutput("rst2_relock", 32'(rx_if.locked), 32'h1);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
